// File: rtl/eth_rx_dispatcher.sv
// Packet-granular demux from the MAC RX Avalon-ST stream to NUM_NICS NIC RX ports.
// Whole frames are steered by destination MAC and pass through one registered output stage.
module eth_rx_dispatcher #(
  parameter int NUM_NICS    = 3,
  parameter int DEFAULT_NIC = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [255:0]            in_data,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [4:0]              in_empty,
  input  logic [5:0]              in_error,
  output logic                    in_ready,
  output logic [NUM_NICS*256-1:0] out_data,
  output logic [NUM_NICS-1:0]     out_valid,
  output logic [NUM_NICS-1:0]     out_sop,
  output logic [NUM_NICS-1:0]     out_eop,
  output logic [NUM_NICS*5-1:0]   out_empty,
  output logic [NUM_NICS*6-1:0]   out_error,
  input  logic [NUM_NICS-1:0]     out_ready,
  output logic [NUM_NICS*32-1:0]  pkt_cnt,
  output logic [15:0]             drop_cnt
);

  localparam int DW = (NUM_NICS > 1) ? $clog2(NUM_NICS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   cur_dest;
  logic [DW-1:0]   sop_dest;
  logic [DW-1:0]   load_dest;
  logic [7:0]      mod_byte;
  logic            load;
  logic            load_sop;
  logic            drop;
  logic            accept;
  logic            dest_ready;

  logic            reg_v;
  logic [DW-1:0]   reg_dest;
  logic [255:0]    reg_data;
  logic            reg_sop;
  logic            reg_eop;
  logic [4:0]      reg_empty;
  logic [5:0]      reg_error;

  // Handshake: a beat moves when valid && ready on that side; valid never waits on ready.
  // The input may accept whenever the output register is empty or is draining this cycle.
  always_comb begin
    dest_ready = 1'b0;
    for (int i = 0; i < NUM_NICS; i++) begin
      if (reg_dest == DW'(i)) dest_ready = out_ready[i];
    end
  end

  assign in_ready = !reg_v || dest_ready;
  assign accept   = in_valid && in_ready;

  // Broadcast goes to the default NIC; otherwise the last dst MAC byte picks the port.
  assign mod_byte = in_data[215:208] % 8'(NUM_NICS);
  assign sop_dest = (&in_data[255:208]) ? DW'(DEFAULT_NIC) : DW'(mod_byte);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_sop  = 1'b0;
    load_dest = cur_dest;
    drop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (in_sop) begin
            load      = 1'b1;
            load_sop  = 1'b1;
            load_dest = sop_dest;
            if (!in_eop) state_nxt = ST_IN_PKT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_IN_PKT: begin
        // A stray SOP inside a frame is treated as payload with its SOP flag stripped.
        if (accept) begin
          load = 1'b1;
          if (in_eop) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_dest <= '0;
    end else if (load && load_sop) begin
      cur_dest <= sop_dest;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_v     <= 1'b0;
      reg_dest  <= '0;
      reg_data  <= '0;
      reg_sop   <= 1'b0;
      reg_eop   <= 1'b0;
      reg_empty <= '0;
      reg_error <= '0;
    end else if (load) begin
      reg_v     <= 1'b1;
      reg_dest  <= load_dest;
      reg_data  <= in_data;
      reg_sop   <= load_sop;
      reg_eop   <= in_eop;
      reg_empty <= in_empty;
      reg_error <= in_error;
    end else if (reg_v && dest_ready) begin
      reg_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Every port sees the register contents; only the selected one gets valid.
  for (genvar g = 0; g < NUM_NICS; g++) begin : g_port
    logic [31:0] cnt_q;

    assign out_data[256*g +: 256] = reg_data;
    assign out_valid[g]           = reg_v && (reg_dest == DW'(g));
    assign out_sop[g]             = reg_sop;
    assign out_eop[g]             = reg_eop;
    assign out_empty[5*g +: 5]    = reg_empty;
    assign out_error[6*g +: 6]    = reg_error;
    assign pkt_cnt[32*g +: 32]    = cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else if (out_valid[g] && out_ready[g] && reg_eop) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_dispatcher.sv
// Bench for eth_rx_dispatcher: directed frame scenarios plus randomized traffic,
// checked each cycle against a frame-level reference model with an expected-beat queue.
module tb_eth_rx_dispatcher;

  localparam int N   = 3;
  localparam int DEF = 0;
  localparam int BW  = 269;      // data, sop, eop, empty, error
  localparam int W   = BW + 2;   // plus destination port

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [255:0]     in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_sop = 1'b0;
  logic             in_eop = 1'b0;
  logic [4:0]       in_empty = '0;
  logic [5:0]       in_error = '0;
  logic             in_ready;
  logic [N*256-1:0] out_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_sop;
  logic [N-1:0]     out_eop;
  logic [N*5-1:0]   out_empty;
  logic [N*6-1:0]   out_error;
  logic [N-1:0]     out_ready = '1;
  logic [N*32-1:0]  pkt_cnt;
  logic [15:0]      drop_cnt;

  logic [W-1:0] exp_q[$];
  int           exp_pkt[N];
  int           exp_drop;
  bit           in_frame;
  int           cur;
  int           n_checks;
  int           n_fail;
  int           rdy_mode;

  eth_rx_dispatcher #(.NUM_NICS(N), .DEFAULT_NIC(DEF)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_error(in_error), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_error(out_error), .out_ready(out_ready),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [299:0] got, input logic [299:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_clear();
    exp_q.delete();
    in_frame = 1'b0;
    cur      = 0;
    exp_drop = 0;
    for (int i = 0; i < N; i++) exp_pkt[i] = 0;
  endfunction

  function automatic void model_accept();
    int d;
    if (!in_frame) begin
      if (in_sop) begin
        d = (in_data[255:208] == 48'hFFFF_FFFF_FFFF) ? DEF : int'(in_data[215:208]) % N;
        cur = d;
        exp_q.push_back({2'(d), in_data, 1'b1, in_eop, in_empty, in_error});
        if (in_eop) exp_pkt[d]++;
        else        in_frame = 1'b1;
      end else if (exp_drop < 65535) begin
        exp_drop++;
      end
    end else begin
      exp_q.push_back({2'(cur), in_data, 1'b0, in_eop, in_empty, in_error});
      if (in_eop) begin
        exp_pkt[cur]++;
        in_frame = 1'b0;
      end
    end
  endfunction

  // ---------------- scoreboard (samples on the falling edge) ----------------
  always @(negedge clk) begin
    logic [W-1:0] f;
    logic [N-1:0] ev;
    int           d;
    bit           has;
    if (reset_n) begin
      has = exp_q.size() > 0;
      ev  = '0;
      d   = 0;
      f   = '0;
      if (has) begin
        f     = exp_q[0];
        d     = int'(f[W-1:BW]);
        ev[d] = 1'b1;
      end
      check_eq("out_valid", out_valid, ev);
      if (has) begin
        for (int i = 0; i < N; i++) begin
          check_eq($sformatf("beat_lane%0d", i),
                   {out_data[256*i +: 256], out_sop[i], out_eop[i],
                    out_empty[5*i +: 5], out_error[6*i +: 6]}, f[BW-1:0]);
        end
      end
      check_eq("in_ready", in_ready, !has || out_ready[d]);
      if (has && out_ready[d]) void'(exp_q.pop_front());
      if (in_valid && in_ready) model_accept();
    end
  end

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      out_ready = '1;
    end else if (rdy_mode == 1) begin
      for (int i = 0; i < N; i++) out_ready[i] = ($urandom_range(0, 9) < 7);
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic send_beat(input logic [255:0] d, input logic s, input logic e,
                           input logic [4:0] em, input logic [5:0] er);
    bit acc;
    int budget;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_empty = em;
    in_error = er;
    in_valid = 1'b1;
    acc      = 1'b0;
    budget   = 0;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    check_eq("accept_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b5, input bit bcast, input int nb, input int mid_sop);
    logic [255:0] d;
    for (int k = 0; k < nb; k++) begin
      d = rand256();
      if (k == 0) begin
        if (bcast) begin
          d[255:208] = 48'hFFFF_FFFF_FFFF;
        end else begin
          d[215:208] = b5;
          if (&d[255:216]) d[255] = 1'b0;
        end
      end
      send_beat(d, (k == 0) || (k == mid_sop), k == nb - 1,
                (k == nb - 1) ? 5'($urandom_range(0, 31)) : 5'd0,
                6'($urandom_range(0, 63)));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiesce_check(input string tag);
    int b;
    rdy_mode = 0;
    b = 0;
    while (exp_q.size() > 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    check_eq({tag, "_drain"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s_pkt_cnt%0d", tag, i), pkt_cnt[32*i +: 32], 32'(exp_pkt[i]));
    end
    check_eq({tag, "_drop_cnt"}, drop_cnt, 16'(exp_drop));
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_out_valid"}, out_valid, '0);
    check_eq({tag, "_out_data_zero"}, out_data == '0, 1'b1);
    check_eq({tag, "_out_fields"}, {out_sop, out_eop, out_empty, out_error}, '0);
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    check_eq({tag, "_pkt_cnt"}, pkt_cnt, '0);
    check_eq({tag, "_drop_cnt"}, drop_cnt, '0);
  endtask

  task automatic apply_reset(input string tag);
    #3;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    reset_checks(tag);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    time t0;
    int  nb;
    int  ms;
    rdy_mode = 0;
    model_clear();
    #2;
    reset_checks("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    // 64B frame to port 1 (dst byte5 = 4)
    send_frame(8'h04, 1'b0, 2, -1);
    quiesce_check("t1");

    // broadcast single-beat frame
    send_frame(8'h00, 1'b1, 1, -1);
    quiesce_check("t2");

    // 3-beat frame to port 2 with a 5-cycle stall mid-frame
    rdy_mode  = 2;
    out_ready = '1;
    fork
      send_frame(8'h02, 1'b0, 3, -1);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 3'b011;
        repeat (5) @(posedge clk);
        #1 out_ready = 3'b111;
      end
    join
    quiesce_check("t3");

    // stray non-SOP beat while idle, then a good frame
    send_beat(rand256(), 1'b0, 1'b0, 5'd0, 6'd0);
    send_frame(8'h03, 1'b0, 2, -1);
    quiesce_check("t4");
    check_eq("t4_drop_one", drop_cnt, 16'd1);

    // back-to-back frames to 0,1,2,0 at full rate after a clean reset
    apply_reset("t5_rst");
    idle(1);
    t0 = $time;
    send_frame(8'h00, 1'b0, 2, -1);
    send_frame(8'h07, 1'b0, 2, -1);
    send_frame(8'h05, 1'b0, 2, -1);
    send_frame(8'h09, 1'b0, 2, -1);
    check_eq("t5_cycles", ($time - t0) / 10, 8);
    quiesce_check("t5");
    check_eq("t5_pkt_cnt_all", pkt_cnt, {32'd1, 32'd1, 32'd2});

    // reset in the middle of a frame, then a fresh frame to port 2
    send_frame(8'h01, 1'b0, 1, -1);
    send_beat(rand256(), 1'b1, 1'b0, 5'd0, 6'd0);
    send_beat(rand256(), 1'b0, 1'b0, 5'd0, 6'd0);
    apply_reset("t6_rst");
    idle(1);
    send_frame(8'h08, 1'b0, 3, -1);
    quiesce_check("t6");

    // randomized traffic with random backpressure, stray beats and in-frame SOPs
    rdy_mode = 1;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_beat(rand256(), 1'b0, 1'($urandom_range(0, 1)), 5'd0, 6'd0);
      end else begin
        nb = $urandom_range(1, 4);
        ms = (nb >= 3 && $urandom_range(0, 4) == 0) ? $urandom_range(1, nb - 1) : -1;
        send_frame(8'($urandom), $urandom_range(0, 9) == 0, nb, ms);
      end
      idle($urandom_range(0, 2));
      if (it % 50 == 49) begin
        quiesce_check("rnd");
        rdy_mode = 1;
      end
    end
    quiesce_check("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
